// File: rtl/cache_line_fill_ctrl_if.sv
// Memory-side request/response bus between the cache line fill controller and main memory.
interface cache_line_fill_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   modport master (output mem_en, mem_wr, mem_addr, mem_wdata, input mem_rdata, mem_valid);
   modport slave  (input mem_en, mem_wr, mem_addr, mem_wdata, output mem_rdata, mem_valid);
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Cache miss controller: optional dirty-victim write-back, then a pipelined line fill and a final tag write.
module cache_line_fill_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     miss_i,
   input  logic [ADDR_W-1:0]        miss_addr_i,
   input  logic                     victim_dirty_i,
   input  logic [ADDR_W-1:0]        victim_addr_i,
   input  logic [DATA_W-1:0]        victim_rdata_i,
   output logic                     busy_o,
   output logic [$clog2(WORDS)-1:0] victim_word_o,
   output logic                     data_we_o,
   output logic [$clog2(WORDS)-1:0] data_word_o,
   output logic [DATA_W-1:0]        data_wdata_o,
   output logic                     tag_we_o,
   cache_line_fill_ctrl_if.master   mem
);
   localparam int OFF_W    = $clog2(DATA_W / 8);
   localparam int WSEL_W   = $clog2(WORDS);
   localparam int LINE_LSB = OFF_W + WSEL_W;
   localparam int BASE_W   = ADDR_W - LINE_LSB;

   typedef enum logic [1:0] {IDLE, WB, FILL, TAG} state_e;

   state_e              state_q, state_d;
   logic [BASE_W-1:0]   missBase_q, missBase_d;
   logic [BASE_W-1:0]   victimBase_q, victimBase_d;
   logic [WSEL_W-1:0]   wc_q, wc_d;
   logic [WSEL_W:0]     ic_q, ic_d;
   logic [WSEL_W:0]     rc_q, rc_d;
   logic                memEn_q, memEn_d;
   logic                memWr_q, memWr_d;
   logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
   logic [WSEL_W-1:0]   victimWord_q, victimWord_d;
   logic                tagWe_q, tagWe_d;
   logic                unusedOffsetBits;

   assign unusedOffsetBits = ^{miss_addr_i[LINE_LSB-1:0], victim_addr_i[LINE_LSB-1:0]};

   function automatic logic [ADDR_W-1:0] lineAddr(input logic [BASE_W-1:0] base,
                                                  input logic [WSEL_W-1:0] word);
      lineAddr = ADDR_W'({base, word}) << OFF_W;
   endfunction

   always_comb begin
      state_d      = state_q;
      missBase_d   = missBase_q;
      victimBase_d = victimBase_q;
      wc_d         = wc_q;
      ic_d         = ic_q;
      rc_d         = rc_q;
      case (state_q)
         IDLE: begin
            if (miss_i) begin
               missBase_d   = miss_addr_i[ADDR_W-1:LINE_LSB];
               victimBase_d = victim_addr_i[ADDR_W-1:LINE_LSB];
               wc_d         = '0;
               ic_d         = '0;
               rc_d         = '0;
               state_d      = victim_dirty_i ? WB : FILL;
            end
         end
         WB: begin
            wc_d = wc_q + 1'b1;
            if (wc_q == WSEL_W'(WORDS - 1)) begin
               state_d = FILL;
               wc_d    = '0;
               ic_d    = '0;
               rc_d    = '0;
            end
         end
         FILL: begin
            // Issue and return sides advance independently; only the final return ends the fill.
            if (!ic_q[WSEL_W]) ic_d = ic_q + 1'b1;
            if (mem.mem_valid) begin
               rc_d = rc_q + 1'b1;
               if (rc_d[WSEL_W]) state_d = TAG;
            end
         end
         TAG:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Request outputs are computed from the next state so they come straight out of flops.
      memEn_d      = 1'b0;
      memWr_d      = 1'b0;
      memAddr_d    = '0;
      victimWord_d = '0;
      tagWe_d      = 1'b0;
      case (state_d)
         WB: begin
            memEn_d      = 1'b1;
            memWr_d      = 1'b1;
            memAddr_d    = lineAddr(victimBase_d, wc_d);
            victimWord_d = wc_d;
         end
         FILL: begin
            if (!ic_d[WSEL_W]) begin
               memEn_d   = 1'b1;
               memAddr_d = lineAddr(missBase_d, ic_d[WSEL_W-1:0]);
            end
         end
         TAG:     tagWe_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         missBase_q   <= '0;
         victimBase_q <= '0;
         wc_q         <= '0;
         ic_q         <= '0;
         rc_q         <= '0;
         memEn_q      <= 1'b0;
         memWr_q      <= 1'b0;
         memAddr_q    <= '0;
         victimWord_q <= '0;
         tagWe_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         missBase_q   <= missBase_d;
         victimBase_q <= victimBase_d;
         wc_q         <= wc_d;
         ic_q         <= ic_d;
         rc_q         <= rc_d;
         memEn_q      <= memEn_d;
         memWr_q      <= memWr_d;
         memAddr_q    <= memAddr_d;
         victimWord_q <= victimWord_d;
         tagWe_q      <= tagWe_d;
      end
   end

   assign busy_o        = (state_q != IDLE) || miss_i;
   assign victim_word_o = victimWord_q;
   assign tag_we_o      = tagWe_q;
   assign data_we_o     = (state_q == FILL) && mem.mem_valid;
   assign data_word_o   = data_we_o ? rc_q[WSEL_W-1:0] : '0;
   assign data_wdata_o  = data_we_o ? mem.mem_rdata : '0;

   assign mem.mem_en    = memEn_q;
   assign mem.mem_wr    = memWr_q;
   assign mem.mem_addr  = memAddr_q;
   assign mem.mem_wdata = memWr_q ? victim_rdata_i : '0;
endmodule
